execute_md: RTL
===============

Name: execute_md

Overview:
- Parametrised execute stage for the pipelined RV32 core, the successor to the single-cycle execute stage.
- Keeps the ALU, branch resolution and operand forwarding. Forwarding is fixed so that forwarded operands reach the store-data path and the branch comparator.
- Adds an iterative multiply/divide unit (RV32M: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) with a stall handshake to the hazard unit.
- Sits between the decode/execute and execute/memory pipeline registers.

Parameters:
- DATA_WIDTH, 32, datapath width (even, ≥8).
- ADDRESS_WIDTH, 32, PC width.
- MD_STEPS, DATA_WIDTH, iterations per mul/div op (one result bit per step). Only DATA_WIDTH is legal in this revision.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- reg_write_d, mem_write_d, jump_d, branch_d  in  1  decode control.
- res_src_d  in  2  result select.
- alu_control_d  in  4  ALU op.
- funct3_d  in  3  branch/load-store/mul-div sub-op.
- alu_src_a_d, alu_src_b_d  in  1  operand A = PC / operand B = immediate select.
- md_valid_d  in  1  current instruction is RV32M.
- rd1_d, rd2_d, imm_val_d  in  DATA_WIDTH  register operands, immediate.
- pc_d, pc_plus4_d  in  ADDRESS_WIDTH  PC, PC+4.
- rd_d  in  5  destination register.
- alu_result_m, result_w  in  DATA_WIDTH  forwarding sources.
- forward_a_e, forward_b_e  in  2  forwarding selects: 00 = reg, 01 = mem stage, 10 = writeback.
- flush_e  in  1  kill the execute-stage instruction.
- reg_write_e, mem_write_e  out  1  passthrough.
- res_src_e  out  2  passthrough.
- funct3_e  out  3  passthrough.
- rd_e  out  5  passthrough.
- pc_plus4_e  out  ADDRESS_WIDTH  passthrough.
- alu_result_e  out  DATA_WIDTH  ALU or mul/div result.
- write_data_e  out  DATA_WIDTH  forwarded operand B (store data).
- pc_target_e  out  ADDRESS_WIDTH  branch/jump target.
- pc_src_e  out  1  redirect fetch.
- md_stall_e  out  1  hold the decode/execute registers and earlier stages.
- md_busy_e  out  1  FSM not in IDLE.

Behaviour:
- Forwarding: fa/fb = mux(forward_x_e: 00 reg, 01 alu_result_m, 10 result_w, 11 reg). fa/fb feed the ALU, the branch comparator and write_data_e.
- ALU operands: A = alu_src_a_d ? pc_d : fa; B = alu_src_b_d ? imm_val_d : fb.
- Branch/jump: pc_target_e = ALU result. pc_src_e = (jump_d | branch_d & cond(funct3_d, fa, fb)) & ~md_stall_e & ~flush_e.
- Mul/div FSM states IDLE, BUSY, DONE. Reset → IDLE; step counter = 0; internal accumulator, quotient, remainder and operand registers = 0.
  - IDLE & md_valid_d & ~flush_e: latch fa, fb and funct3_d; take operand magnitudes per signedness; go to BUSY. md_stall_e = 1 combinationally in this cycle.
  - BUSY: one shift-add (mul) or restoring-subtract (div) step per cycle. Counter runs 0..MD_STEPS-1. At MD_STEPS-1 apply sign fix-up and register the result; go to DONE. md_stall_e = 1.
  - DONE: md_stall_e = 0. alu_result_e = registered mul/div result. The pipeline advances at the end of this cycle. Go to IDLE unconditionally; md_valid_d is ignored in DONE so the same instruction never restarts.
- Latency: the request cycle plus MD_STEPS BUSY cycles give MD_STEPS+1 stall cycles; the result is presented in cycle MD_STEPS+1 after the request.
- Non-md instructions: alu_result_e = ALU result, 0 extra latency.
- Result selection:
  - MUL: low half of the product.
  - MULH, MULHSU, MULHU: high half with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
  - DIV/DIVU: quotient. REM/REMU: remainder.
- Remainder sign follows the dividend; the quotient rounds toward zero.
- Divide by zero: quotient = all ones; remainder = dividend. The unit still takes the full latency.
- Signed overflow (MIN / -1): quotient = MIN; remainder = 0.
- flush_e:
  - Forces md_stall_e = 0 combinationally.
  - Next state is IDLE with counter = 0, from any state.
  - Has priority over a new md_valid_d.
- rst mid-operation: next cycle IDLE, md_stall_e = 0, no result produced.
- Passthroughs stay combinational. Control outputs are not gated by stall; the hazard unit uses md_stall_e to bubble.

Test Plan:
- Forwarding: rd1_d=9, alu_result_m=5, forward_a_e=01, imm 3, ADD with B = imm → alu_result_e=8. forward_b_e=10 with result_w=0x1234 → write_data_e=0x1234.
- MUL 7 × 0xFFFFFFFD (-3) → md_stall_e high for exactly 33 cycles; in DONE alu_result_e=0xFFFFFFEB; md_busy_e low one cycle later. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- DIV 100/0 → 0xFFFFFFFF; REM 100/0 → 100. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0. REM -7/2 → 0xFFFFFFFF (-1).
- flush_e asserted in BUSY at step 10 → md_stall_e=0 that cycle, IDLE next. A following DIVU 20/3 completes in 33 stall cycles → result 6.
- rst asserted mid-BUSY → IDLE, md_stall_e=0, md_busy_e=0 next cycle. BEQ with fa=fb=4, branch_d=1 after reset → pc_src_e=1, pc_target_e = pc_d + imm.
- Back-to-back MUL then DIV (md_valid_d high in consecutive accepted instructions) → no restart in DONE; the second op starts in the cycle after DONE; both results are correct.

Source files
------------

// File: rtl/execute_md_if.sv
// rtl/execute_md_if.sv - decode/execute to execute/memory signal bundle for the execute stage
interface execute_md_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
);
    logic                     reg_write_d;
    logic                     mem_write_d;
    logic                     jump_d;
    logic                     branch_d;
    logic [1:0]               res_src_d;
    logic [3:0]               alu_control_d;
    logic [2:0]               funct3_d;
    logic                     alu_src_a_d;
    logic                     alu_src_b_d;
    logic                     md_valid_d;
    logic [DATA_WIDTH-1:0]    rd1_d;
    logic [DATA_WIDTH-1:0]    rd2_d;
    logic [DATA_WIDTH-1:0]    imm_val_d;
    logic [ADDRESS_WIDTH-1:0] pc_d;
    logic [ADDRESS_WIDTH-1:0] pc_plus4_d;
    logic [4:0]               rd_d;
    logic [DATA_WIDTH-1:0]    alu_result_m;
    logic [DATA_WIDTH-1:0]    result_w;
    logic [1:0]               forward_a_e;
    logic [1:0]               forward_b_e;
    logic                     flush_e;

    logic                     reg_write_e;
    logic                     mem_write_e;
    logic [1:0]               res_src_e;
    logic [2:0]               funct3_e;
    logic [4:0]               rd_e;
    logic [ADDRESS_WIDTH-1:0] pc_plus4_e;
    logic [DATA_WIDTH-1:0]    alu_result_e;
    logic [DATA_WIDTH-1:0]    write_data_e;
    logic [ADDRESS_WIDTH-1:0] pc_target_e;
    logic                     pc_src_e;
    logic                     md_stall_e;
    logic                     md_busy_e;

    modport master (
        output reg_write_d, mem_write_d, jump_d, branch_d, res_src_d, alu_control_d,
               funct3_d, alu_src_a_d, alu_src_b_d, md_valid_d, rd1_d, rd2_d, imm_val_d,
               pc_d, pc_plus4_d, rd_d, alu_result_m, result_w, forward_a_e, forward_b_e,
               flush_e,
        input  reg_write_e, mem_write_e, res_src_e, funct3_e, rd_e, pc_plus4_e,
               alu_result_e, write_data_e, pc_target_e, pc_src_e, md_stall_e, md_busy_e
    );

    modport slave (
        input  reg_write_d, mem_write_d, jump_d, branch_d, res_src_d, alu_control_d,
               funct3_d, alu_src_a_d, alu_src_b_d, md_valid_d, rd1_d, rd2_d, imm_val_d,
               pc_d, pc_plus4_d, rd_d, alu_result_m, result_w, forward_a_e, forward_b_e,
               flush_e,
        output reg_write_e, mem_write_e, res_src_e, funct3_e, rd_e, pc_plus4_e,
               alu_result_e, write_data_e, pc_target_e, pc_src_e, md_stall_e, md_busy_e
    );
endinterface

// File: rtl/execute_md.sv
// rtl/execute_md.sv - RV32 execute stage with forwarding, branch resolution and iterative mul/div
module execute_md #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int MD_STEPS      = DATA_WIDTH
) (
    input logic         clk,
    input logic         rst,
    execute_md_if.slave ex
);
    localparam int W   = DATA_WIDTH;
    localparam int SHW = $clog2(W);
    localparam int CW  = $clog2(MD_STEPS);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;
    localparam logic [3:0] ALU_PASS = 4'd10;

    typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;

    md_state_t       state;
    logic [CW-1:0]   cnt;
    logic [2*W-1:0]  acc;
    logic [W-1:0]    mcand;
    logic [W-1:0]    op_a;
    logic [W-1:0]    op_b;
    logic [2:0]      op_f3;
    logic            neg_a;
    logic            neg_b;
    logic [W-1:0]    md_result;

    logic [W-1:0]    fa;
    logic [W-1:0]    fb;
    logic [W-1:0]    alu_a;
    logic [W-1:0]    alu_b;
    logic [W-1:0]    alu_y;
    logic            br_cond;

    logic            in_neg_a;
    logic            in_neg_b;
    logic [W-1:0]    mag_a;
    logic [W-1:0]    mag_b;

    logic [W:0]      step_sum;
    logic [W:0]      step_shift;
    logic [W:0]      step_diff;
    logic [2*W-1:0]  acc_step;
    logic [2*W-1:0]  prod_fix;
    logic [W-1:0]    quo_fix;
    logic [W-1:0]    rem_fix;
    logic [W-1:0]    md_final;

    // Operand forwarding from the memory and writeback stages
    always_comb begin
        fa = ex.rd1_d;
        fb = ex.rd2_d;
        case (ex.forward_a_e)
            2'b01:   fa = ex.alu_result_m;
            2'b10:   fa = ex.result_w;
            default: fa = ex.rd1_d;
        endcase
        case (ex.forward_b_e)
            2'b01:   fb = ex.alu_result_m;
            2'b10:   fb = ex.result_w;
            default: fb = ex.rd2_d;
        endcase
    end

    assign alu_a = ex.alu_src_a_d ? W'(ex.pc_d) : fa;
    assign alu_b = ex.alu_src_b_d ? ex.imm_val_d : fb;

    // Single-cycle ALU
    always_comb begin
        alu_y = '0;
        case (ex.alu_control_d)
            ALU_ADD:  alu_y = alu_a + alu_b;
            ALU_SUB:  alu_y = alu_a - alu_b;
            ALU_AND:  alu_y = alu_a & alu_b;
            ALU_OR:   alu_y = alu_a | alu_b;
            ALU_XOR:  alu_y = alu_a ^ alu_b;
            ALU_SLT:  alu_y = W'($signed(alu_a) < $signed(alu_b));
            ALU_SLTU: alu_y = W'(alu_a < alu_b);
            ALU_SLL:  alu_y = alu_a << alu_b[SHW-1:0];
            ALU_SRL:  alu_y = alu_a >> alu_b[SHW-1:0];
            ALU_SRA:  alu_y = W'($signed(alu_a) >>> alu_b[SHW-1:0]);
            ALU_PASS: alu_y = alu_b;
            default:  alu_y = '0;
        endcase
    end

    // Branch comparator on the forwarded register operands
    always_comb begin
        br_cond = 1'b0;
        case (ex.funct3_d)
            3'b000:  br_cond = (fa == fb);
            3'b001:  br_cond = (fa != fb);
            3'b100:  br_cond = ($signed(fa) < $signed(fb));
            3'b101:  br_cond = ($signed(fa) >= $signed(fb));
            3'b110:  br_cond = (fa < fb);
            3'b111:  br_cond = (fa >= fb);
            default: br_cond = 1'b0;
        endcase
    end

    // Operand signedness and magnitudes for the op being accepted
    always_comb begin
        in_neg_a = 1'b0;
        in_neg_b = 1'b0;
        case (ex.funct3_d)
            3'b001, 3'b100, 3'b110: begin
                in_neg_a = fa[W-1];
                in_neg_b = fb[W-1];
            end
            3'b010:  in_neg_a = fa[W-1];
            default: begin
                in_neg_a = 1'b0;
                in_neg_b = 1'b0;
            end
        endcase
        mag_a = in_neg_a ? (~fa + W'(1)) : fa;
        mag_b = in_neg_b ? (~fb + W'(1)) : fb;
    end

    // One shift-add (mul) or restoring-subtract (div) step, plus the sign fix-up of that step's outcome
    always_comb begin
        step_sum   = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? mcand : {W{1'b0}})};
        step_shift = acc[2*W-1:W-1];
        step_diff  = step_shift - {1'b0, mcand};
        if (op_f3[2]) begin
            if (!step_diff[W]) acc_step = {step_diff[W-1:0], acc[W-2:0], 1'b1};
            else               acc_step = {step_shift[W-1:0], acc[W-2:0], 1'b0};
        end else begin
            acc_step = {step_sum, acc[W-1:1]};
        end

        prod_fix = (neg_a ^ neg_b) ? (~acc_step + (2*W)'(1)) : acc_step;
        if (op_b == '0) begin
            // Division by zero: all-ones quotient, dividend as remainder
            quo_fix = '1;
            rem_fix = op_a;
        end else begin
            quo_fix = (neg_a ^ neg_b) ? (~acc_step[W-1:0] + W'(1)) : acc_step[W-1:0];
            rem_fix = neg_a ? (~acc_step[2*W-1:W] + W'(1)) : acc_step[2*W-1:W];
        end

        case (op_f3)
            3'b000:                 md_final = prod_fix[W-1:0];
            3'b001, 3'b010, 3'b011: md_final = prod_fix[2*W-1:W];
            3'b100, 3'b101:         md_final = quo_fix;
            default:                md_final = rem_fix;
        endcase
    end

    // Mul/div sequencer: accept in IDLE, iterate in BUSY, present the result for one cycle in DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= MD_IDLE;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_f3     <= '0;
            neg_a     <= 1'b0;
            neg_b     <= 1'b0;
            md_result <= '0;
        end else if (ex.flush_e) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (ex.md_valid_d) begin
                        op_a  <= fa;
                        op_b  <= fb;
                        op_f3 <= ex.funct3_d;
                        neg_a <= in_neg_a;
                        neg_b <= in_neg_b;
                        cnt   <= '0;
                        if (ex.funct3_d[2]) begin
                            acc   <= {{W{1'b0}}, mag_a};
                            mcand <= mag_b;
                        end else begin
                            acc   <= {{W{1'b0}}, mag_b};
                            mcand <= mag_a;
                        end
                        state <= MD_BUSY;
                    end
                end
                MD_BUSY: begin
                    acc <= acc_step;
                    if (cnt == CW'(MD_STEPS - 1)) begin
                        md_result <= md_final;
                        cnt       <= '0;
                        state     <= MD_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                MD_DONE: state <= MD_IDLE;
                default: state <= MD_IDLE;
            endcase
        end
    end

    assign ex.md_stall_e   = ~ex.flush_e & ((state == MD_BUSY) | ((state == MD_IDLE) & ex.md_valid_d));
    assign ex.md_busy_e    = (state != MD_IDLE);
    assign ex.alu_result_e = (state == MD_DONE) ? md_result : alu_y;
    assign ex.write_data_e = fb;
    assign ex.pc_target_e  = ADDRESS_WIDTH'(alu_y);
    assign ex.pc_src_e     = (ex.jump_d | (ex.branch_d & br_cond)) & ~ex.md_stall_e & ~ex.flush_e;

    assign ex.reg_write_e  = ex.reg_write_d;
    assign ex.mem_write_e  = ex.mem_write_d;
    assign ex.res_src_e    = ex.res_src_d;
    assign ex.funct3_e     = ex.funct3_d;
    assign ex.rd_e         = ex.rd_d;
    assign ex.pc_plus4_e   = ex.pc_plus4_d;
endmodule
